gpio_debounce: RTL and testbench



---
 rtl/gpio_debounce.sv | 195 +++++++++++++++++++
 tb/tb_gpio_debounce.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_debounce.sv
// gpio_debounce: 2-FF pin synchroniser plus per-pin tick-driven debounce filter, with an 8-word Avalon-MM CSR aperture and a filtered-change irq.
// Latency: pin -> RAW 2 clk, pin -> data_out 3 clk in bypass, or 2 clk plus P prescaler ticks when filtered; readdata is combinational.
// Backpressure: none; the bus completes every access in a single cycle. Define GPIO_DEBOUNCE_GLITCH_CNT_EN to build the GLITCH counter at offset 6.
module gpio_debounce #(
  parameter int               CNT_W        = 8,
  parameter int               PRE_W        = 16,
  parameter logic [CNT_W-1:0] PERIOD_RST   = 8'd4,
  parameter logic [PRE_W-1:0] PRESCALE_RST = 16'd49999
) (
  input  logic        clk,
  input  logic        reset,
  output logic        irq,
  input  logic [2:0]  address,
  input  logic [3:0]  byteenable,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [31:0] pin_in,
  output logic [31:0] data_out
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

  logic [31:0]      r_s1;
  logic [31:0]      r_s2;
  logic [31:0]      r_enable;
  logic [31:0]      r_data_out;
  logic [31:0]      r_changed;
  logic [CNT_W-1:0] r_period;
  logic [PRE_W-1:0] r_prescale;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [CNT_W-1:0] r_cnt [32];

  logic [31:0]      w_be_mask;
  logic             w_wr;
  logic             w_tick;
  logic [CNT_W-1:0] w_p_m1;
  logic [31:0]      w_dout_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [32];
  logic [31:0]      w_changed_clr;
  logic [31:0]      w_enable_wr;
  logic [CNT_W-1:0] w_period_wr;
  logic [PRE_W-1:0] w_prescale_wr;
  logic [31:0]      w_period_ext;
  logic [31:0]      w_prescale_ext;

  assign w_wr      = chipselect & write;
  assign w_be_mask = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign w_tick    = (r_pre_cnt == r_prescale);
  assign data_out  = r_data_out;
  assign irq       = |r_changed;

  // Byte-lane merge of the write data into each writable register
  always_comb begin
    w_enable_wr   = (r_enable & ~w_be_mask) | (writedata & w_be_mask);
    w_period_wr   = (r_period & ~w_be_mask[CNT_W-1:0]) | (writedata[CNT_W-1:0] & w_be_mask[CNT_W-1:0]);
    w_prescale_wr = (r_prescale & ~w_be_mask[PRE_W-1:0]) | (writedata[PRE_W-1:0] & w_be_mask[PRE_W-1:0]);
    w_changed_clr = (w_wr && address == 3'd5) ? (writedata & w_be_mask) : 32'd0;
  end

  // Zero-extend the narrow config registers for readback
  always_comb begin
    w_period_ext                = 32'd0;
    w_period_ext[CNT_W-1:0]     = r_period;
    w_prescale_ext              = 32'd0;
    w_prescale_ext[PRE_W-1:0]   = r_prescale;
  end

  // Effective threshold P-1 where P = max(PERIOD, 1)
  always_comb begin
    w_p_m1 = (r_period == '0) ? '0 : (r_period - CNT_ONE);
  end

  // Per-pin filter next state: bypass follows s2, enabled pins need P ticks of continuous mismatch
  always_comb begin
    w_dout_nxt = r_data_out;
    for (int i = 0; i < 32; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (!r_enable[i]) begin
        w_dout_nxt[i] = r_s2[i];
        w_cnt_nxt[i]  = '0;
      end else if (r_s2[i] == r_data_out[i]) begin
        w_cnt_nxt[i]  = '0;
      end else if (w_tick) begin
        if (r_cnt[i] >= w_p_m1) begin
          w_dout_nxt[i] = r_s2[i];
          w_cnt_nxt[i]  = '0;
        end else begin
          w_cnt_nxt[i]  = r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 32'd0;
      r_s2 <= 32'd0;
    end else begin
      r_s1 <= pin_in;
      r_s2 <= r_s1;
    end
  end

  // Free-running prescaler; a shrunk PRESCALE below the count wraps through the full width
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + PRE_ONE;
    end
  end

  // Configuration registers written through the bus
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable   <= 32'd0;
      r_period   <= PERIOD_RST;
      r_prescale <= PRESCALE_RST;
    end else if (w_wr) begin
      if (address == 3'd0) r_enable   <= w_enable_wr;
      if (address == 3'd1) r_period   <= w_period_wr;
      if (address == 3'd2) r_prescale <= w_prescale_wr;
    end
  end

  // Filtered output and per-pin stability counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= 32'd0;
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
    end else begin
      r_data_out <= w_dout_nxt;
      for (int i = 0; i < 32; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // Sticky change flags; a new change in the clearing cycle keeps the bit set
  always_ff @(posedge clk) begin
    if (reset) begin
      r_changed <= 32'd0;
    end else begin
      r_changed <= (r_changed & ~w_changed_clr) | (r_data_out ^ w_dout_nxt);
    end
  end

`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
  logic [31:0] r_glitch;
  logic [31:0] w_cnt_nz;
  logic        w_abort;

  // An enabled pin whose counter was running and now matches again is an aborted transition
  always_comb begin
    for (int i = 0; i < 32; i++) w_cnt_nz[i] = (r_cnt[i] != '0);
    w_abort = |(r_enable & w_cnt_nz & ~(r_s2 ^ r_data_out));
  end

  // Saturating glitch counter, any write to its offset clears it (clear beats increment)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_glitch <= 32'd0;
    end else if (w_wr && address == 3'd6) begin
      r_glitch <= 32'd0;
    end else if (w_abort && r_glitch != 32'hFFFF_FFFF) begin
      r_glitch <= r_glitch + 32'd1;
    end
  end
`endif

  // Combinational read mux, zero when not reading
  always_comb begin
    readdata = 32'd0;
    if (read && chipselect) begin
      case (address)
        3'd0:    readdata = r_enable;
        3'd1:    readdata = w_period_ext;
        3'd2:    readdata = w_prescale_ext;
        3'd3:    readdata = r_s2;
        3'd4:    readdata = r_data_out;
        3'd5:    readdata = r_changed;
`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
        3'd6:    readdata = r_glitch;
`endif
        default: readdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: register map table, then timing sequences for bypass, debounce, glitch, w1c races and PERIOD=0.
module tb_gpio_debounce;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq;
  logic [2:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] pin_in;
  logic [31:0] data_out;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  gpio_debounce dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .address    (address),
    .byteenable (byteenable),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .pin_in     (pin_in),
    .data_out   (data_out)
  );

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt [19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    chipselect = 1'b1;
    write      = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    read       = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
    read       = 1'b0;
    #1;
  endtask

  // Reset, then step PRESCALE 49999 -> 1 -> 0 on the tick so the prescaler lands at count 0
  task automatic init_fast();
    pin_in = 32'd0;
    reset  = 1'b1;
    step();
    step();
    reset  = 1'b0;
    wr(3'd2, 32'd1, 4'hF);
    wr(3'd2, 32'd0, 4'hF);
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    logic [31:0] glitch_exp;

`ifdef GPIO_DEBOUNCE_GLITCH_CNT_EN
    glitch_exp = 32'd1;
`else
    glitch_exp = 32'd0;
`endif

    vt[0]  = '{1'b0, 3'd0, 32'h0000_0000, 4'h0, 32'h0000_0000, "rst_enable"};
    vt[1]  = '{1'b0, 3'd1, 32'h0000_0000, 4'h0, 32'h0000_0004, "rst_period"};
    vt[2]  = '{1'b0, 3'd2, 32'h0000_0000, 4'h0, 32'h0000_C34F, "rst_prescale"};
    vt[3]  = '{1'b0, 3'd3, 32'h0000_0000, 4'h0, 32'h0000_0000, "rst_raw"};
    vt[4]  = '{1'b0, 3'd4, 32'h0000_0000, 4'h0, 32'h0000_0000, "rst_filtered"};
    vt[5]  = '{1'b0, 3'd5, 32'h0000_0000, 4'h0, 32'h0000_0000, "rst_changed"};
    vt[6]  = '{1'b0, 3'd6, 32'h0000_0000, 4'h0, 32'h0000_0000, "rst_glitch"};
    vt[7]  = '{1'b0, 3'd7, 32'h0000_0000, 4'h0, 32'h0000_0000, "rst_reserved"};
    vt[8]  = '{1'b1, 3'd0, 32'hFFFF_FFFF, 4'b0010, 32'h0000_FF00, "enable_be1"};
    vt[9]  = '{1'b1, 3'd0, 32'h1234_5678, 4'b1001, 32'h1200_FF78, "enable_be9"};
    vt[10] = '{1'b1, 3'd1, 32'h1234_5603, 4'b0001, 32'h0000_0003, "period_be0"};
    vt[11] = '{1'b1, 3'd1, 32'hFFFF_FFFF, 4'b1110, 32'h0000_0003, "period_upper"};
    vt[12] = '{1'b1, 3'd2, 32'hABCD_0009, 4'b1111, 32'h0000_0009, "prescale_full"};
    vt[13] = '{1'b1, 3'd2, 32'h0000_FF00, 4'b0010, 32'h0000_FF09, "prescale_be1"};
    vt[14] = '{1'b1, 3'd3, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, "raw_ro"};
    vt[15] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, "reserved_wr"};
    vt[16] = '{1'b1, 3'd0, 32'h0000_0000, 4'b1111, 32'h0000_0000, "enable_clr"};
    vt[17] = '{1'b1, 3'd5, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, "changed_w1c_idle"};
    vt[18] = '{1'b1, 3'd4, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, "filtered_ro"};

    reset      = 1'b1;
    address    = 3'd0;
    byteenable = 4'h0;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = 32'd0;
    pin_in     = 32'd0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Register map table
    for (int i = 0; i < 19; i++) begin
      if (vt[i].wr) wr(vt[i].addr, vt[i].wdata, vt[i].be);
      rd(vt[i].addr, d);
      check(vt[i].name, d, vt[i].exp);
    end

    // readdata gated by read
    address    = 3'd1;
    chipselect = 1'b1;
    read       = 1'b0;
    #1;
    check("rd_gate", readdata, 32'd0);
    chipselect = 1'b0;

    // Bypass: RAW after 2 clk, data_out after 3 clk
    pin_in = 32'h0000_00A5;
    step();
    rd(3'd3, d);
    check("raw_lat1", d, 32'd0);
    step();
    rd(3'd3, d);
    check("raw_lat2", d, 32'h0000_00A5);
    check("byp_lat2", data_out, 32'd0);
    step();
    check("byp_lat3", data_out, 32'h0000_00A5);
    rd(3'd5, d);
    check("byp_changed", d, 32'h0000_00A5);
    check("byp_irq", {31'd0, irq}, 32'd1);
    wr(3'd5, 32'h0000_0005, 4'hF);
    rd(3'd5, d);
    check("byp_w1c", d, 32'h0000_00A0);
    check("byp_irq_hold", {31'd0, irq}, 32'd1);

    // Reset with live state discards it
    reset = 1'b1;
    step();
    rd(3'd4, d);
    check("mid_rst_filtered", d, 32'd0);
    rd(3'd5, d);
    check("mid_rst_changed", d, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);

    // Glitch rejection: 3-clk pulse against PERIOD=5
    init_fast();
    wr(3'd1, 32'd5, 4'hF);
    wr(3'd0, 32'd1, 4'hF);
    pin_in = 32'd1;
    repeat (3) step();
    pin_in = 32'd0;
    repeat (10) step();
    check("glitch_dout", data_out, 32'd0);
    rd(3'd5, d);
    check("glitch_changed", d, 32'd0);
    rd(3'd6, d);
    check("glitch_count", d, glitch_exp);
    wr(3'd6, 32'd0, 4'h0);
    rd(3'd6, d);
    check("glitch_clear", d, 32'd0);

    // Debounce PERIOD=3, tick every clk: rises 3 clk after s2
    wr(3'd1, 32'd3, 4'hF);
    pin_in = 32'd1;
    step();
    step();
    step();
    check("deb_e3", data_out, 32'd0);
    step();
    check("deb_e4", data_out, 32'd0);
    step();
    check("deb_e5", data_out, 32'd1);
    rd(3'd5, d);
    check("deb_changed", d, 32'd1);
    pin_in = 32'd0;
    repeat (8) step();
    check("deb_fall", data_out, 32'd0);
    wr(3'd5, 32'hFFFF_FFFF, 4'hF);
    check("deb_irq_clr", {31'd0, irq}, 32'd0);

    // Debounce with PRESCALE=9: three ticks of 10 clk
    wr(3'd2, 32'd9, 4'hF);
    pin_in = 32'd1;
    n = 0;
    while (data_out[0] == 1'b0 && n < 60) begin
      step();
      n++;
    end
    n_checks++;
    if (!(n >= 23 && n <= 32)) begin
      n_err++;
      $display("FAIL pre9_latency: actual=%0d clk required=23..32", n);
    end

    // Change and w1c in the same clk: set wins
    init_fast();
    pin_in = 32'h0000_0004;
    step();
    step();
    wr(3'd5, 32'h0000_0004, 4'hF);
    check("race_dout", data_out, 32'h0000_0004);
    rd(3'd5, d);
    check("race_changed", d, 32'h0000_0004);
    wr(3'd5, 32'h0000_0004, 4'hF);
    rd(3'd5, d);
    check("race_clear", d, 32'd0);

    // PERIOD=0 acts as 1 tick
    wr(3'd0, 32'hFFFF_FFFF, 4'b0010);
    rd(3'd0, d);
    check("p0_enable", d, 32'h0000_FF00);
    wr(3'd1, 32'd0, 4'hF);
    rd(3'd1, d);
    check("p0_period", d, 32'd0);
    pin_in = 32'h0000_0104;
    step();
    step();
    check("p0_e2", data_out & 32'h0000_0100, 32'd0);
    step();
    check("p0_e3", data_out & 32'h0000_0100, 32'h0000_0100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
